uart_autobaud: RTL and testbench

UART_AUTOBAUD -- requirements
Module: uart_autobaud

---
 rtl/uart_autobaud.sv | 187 ++++++++++++++++++
 tb/tb_uart_autobaud.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// Measures a 0x55 sync character on rxd and derives the UART receiver prescale (bit period = prescale*8 clk).
// Result is registered one cycle after the stop-bit rising edge; no backpressure, start is ignored while busy.
module uart_autobaud #(
  parameter int unsigned CNT_WIDTH        = 24,
  parameter int unsigned IDLE_CYCLES      = 1024,
  parameter int unsigned TIMEOUT_CYCLES   = 1048576,
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rxd,
  output logic [15:0] prescale,
  output logic        locked,
  output logic        done,
  output logic        error,
  output logic        busy,
  output logic        rx_hold
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_IDLE  = 3'd1,
    WAIT_START = 3'd2,
    MEASURE    = 3'd3,
    STOP       = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MIN_W     = CNT_WIDTH'(8);
  localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(IDLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH:0]   P_ROUND   = (CNT_WIDTH+1)'(32);
  localparam logic [CNT_WIDTH:0]   P_MAX     = (CNT_WIDTH+1)'(65535);

  state_t               state;
  logic                 sync1, sync2, rxd_d;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [CNT_WIDTH-1:0] high_cnt;
  logic [CNT_WIDTH-1:0] tot_cnt;
  logic [CNT_WIDTH-1:0] w_val;
  logic [CNT_WIDTH-1:0] t_val;
  logic [3:0]           edge_cnt;

  logic                 rise, fall, any_edge;
  logic                 wait_sat, tot_sat, timeout;
  logic [CNT_WIDTH-1:0] interval, w_half;
  logic [CNT_WIDTH:0]   w_dbl, p_sum, p_full;
  logic                 interval_ok, p_ok, fail;

  // The wait counter restarts on every counted edge, so in MEASURE/STOP it also
  // serves as the interval counter: the interval ending at an edge is wait_cnt+1.
  always_comb begin
    rise        = sync2 & ~rxd_d;
    fall        = ~sync2 & rxd_d;
    any_edge    = rise | fall;
    wait_sat    = (wait_cnt == CNT_MAX);
    tot_sat     = (tot_cnt == CNT_MAX);
    timeout     = wait_sat || (wait_cnt >= TO_LAST);
    interval    = wait_cnt + CNT_ONE;
    w_half      = w_val >> 1;
    w_dbl       = {w_val, 1'b0};
    interval_ok = !wait_sat && (interval >= w_half) && ({1'b0, interval} <= w_dbl);
    p_sum       = {1'b0, t_val} + P_ROUND;
    p_full      = p_sum >> 6;
    p_ok        = (p_full != '0) && (p_full <= P_MAX);

    fail = 1'b0;
    case (state)
      WAIT_IDLE:  fail = timeout;
      WAIT_START: fail = !fall && timeout;
      MEASURE: begin
        if (any_edge) begin
          if (edge_cnt == 4'd1) fail = tot_sat || wait_sat || (interval < MIN_W);
          else                  fail = tot_sat || !interval_ok;
        end else begin
          fail = timeout || tot_sat;
        end
      end
      STOP:       fail = rise ? (!interval_ok || !p_ok) : timeout;
      default:    fail = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rxd_d    <= 1'b1;
      wait_cnt <= '0;
      high_cnt <= '0;
      tot_cnt  <= '0;
      w_val    <= '0;
      t_val    <= '0;
      edge_cnt <= '0;
      prescale <= DEFAULT_PRESCALE;
      locked   <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      rxd_d <= sync2;
      done  <= 1'b0;
      error <= 1'b0;

      if (fail) begin
        state <= IDLE;
        busy  <= 1'b0;
        error <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= WAIT_IDLE;
              busy     <= 1'b1;
              wait_cnt <= '0;
              high_cnt <= '0;
            end
          end

          WAIT_IDLE: begin
            wait_cnt <= wait_cnt + CNT_ONE;
            if (!sync2) begin
              high_cnt <= '0;
            end else if (high_cnt >= IDLE_LAST) begin
              state    <= WAIT_START;
              wait_cnt <= '0;
            end else begin
              high_cnt <= high_cnt + CNT_ONE;
            end
          end

          WAIT_START: begin
            if (fall) begin
              state    <= MEASURE;
              wait_cnt <= '0;
              tot_cnt  <= '0;
              edge_cnt <= 4'd1;
            end else begin
              wait_cnt <= wait_cnt + CNT_ONE;
            end
          end

          MEASURE: begin
            tot_cnt <= tot_cnt + CNT_ONE;
            if (any_edge) begin
              wait_cnt <= '0;
              edge_cnt <= edge_cnt + 4'd1;
              if (edge_cnt == 4'd1) w_val <= interval;
              // edge_cnt counts edges already seen, so 8 here means this is edge 9
              if (edge_cnt == 4'd8) begin
                t_val <= tot_cnt + CNT_ONE;
                state <= STOP;
              end
            end else begin
              wait_cnt <= wait_cnt + CNT_ONE;
            end
          end

          STOP: begin
            if (rise) begin
              state    <= IDLE;
              busy     <= 1'b0;
              prescale <= p_full[15:0];
              locked   <= 1'b1;
              done     <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CNT_ONE;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_hold = busy;

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: frames are driven with exact per-bit cycle lengths and
// the outcome is predicted from the frame's edge times by a behavioural model.
module tb_uart_autobaud;

  localparam int TO = 8000;

  typedef int lens_t[10];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rxd;
  logic [15:0] prescale;
  logic        locked, done, error, busy, rx_hold;

  int checks = 0;
  int errors = 0;
  int done_cycles = 0;
  int err_cycles = 0;

  logic [15:0] exp_prescale;
  logic        exp_locked;

  always #5 clk = ~clk;

  uart_autobaud #(
    .CNT_WIDTH(24),
    .IDLE_CYCLES(1024),
    .TIMEOUT_CYCLES(TO),
    .DEFAULT_PRESCALE(16'd1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rxd(rxd),
    .prescale(prescale),
    .locked(locked),
    .done(done),
    .error(error),
    .busy(busy),
    .rx_hold(rx_hold)
  );

  // Pulse counting plus the invariants that must hold whenever a result is reported.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cycles++;
      if (error) err_cycles++;
      if (done || error) begin
        checks++;
        if (done && error) begin
          errors++;
          $display("FAIL pulse_exclusive: done=%0b error=%0b, required not both", done, error);
        end
        checks++;
        if (busy !== 1'b0 || rx_hold !== 1'b0) begin
          errors++;
          $display("FAIL busy_on_result: busy=%0b rx_hold=%0b, required 0 0", busy, rx_hold);
        end
      end
    end
  end

  // Frame outcome from edge times: edge 1 is the start-bit fall, W the first interval,
  // every later interval within [W/2, 2W], T from edge 1 to edge 9, edge 10 the stop rise.
  function automatic void model(input logic [7:0] ch, input lens_t lens, output bit ok, output int p);
    int e[$];
    logic [9:0] lev;
    logic prev;
    int t, w;
    bit bad;
    lev = {1'b1, ch, 1'b0};
    prev = 1'b1;
    t = 0;
    for (int i = 0; i < 10; i++) begin
      if (lev[i] !== prev) e.push_back(t);
      prev = lev[i];
      t += lens[i];
    end
    bad = 0;
    w = 0;
    for (int k = 1; k < e.size() && k <= 9 && !bad; k++) begin
      int iv;
      iv = e[k] - e[k-1];
      if (iv > TO) bad = 1;
      else if (k == 1) begin
        w = iv;
        if (w < 8) bad = 1;
      end else if (iv < w / 2 || iv > 2 * w) bad = 1;
    end
    if (!bad && e.size() < 10) bad = 1;
    p = 0;
    if (!bad) begin
      p = (e[8] - e[0] + 32) / 64;
      if (p < 1 || p > 65535) bad = 1;
    end
    ok = !bad;
  endfunction

  task automatic fill(output lens_t l, input int n);
    for (int i = 0; i < 10; i++) l[i] = n;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_high(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] ch, input lens_t lens, input int nbits);
    logic [9:0] lev;
    lev = {1'b1, ch, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rxd = lev[i];
      repeat (lens[i]) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic finish_frame(input string name, input bit ok, input int p, input int d0, input int e0);
    int budget;
    budget = 0;
    while (done_cycles + err_cycles == d0 + e0 && budget < TO + 300) begin
      @(negedge clk);
      budget++;
    end
    repeat (4) @(negedge clk);
    if (ok) begin
      exp_prescale = p[15:0];
      exp_locked = 1'b1;
    end
    checks++;
    if (done_cycles - d0 !== (ok ? 1 : 0) || err_cycles - e0 !== (ok ? 0 : 1)) begin
      errors++;
      $display("FAIL %s outcome: done pulses %0d error pulses %0d, required %0d %0d",
               name, done_cycles - d0, err_cycles - e0, ok ? 1 : 0, ok ? 0 : 1);
    end
    checks++;
    if (prescale !== exp_prescale) begin
      errors++;
      $display("FAIL %s prescale: got %0d expected %0d", name, prescale, exp_prescale);
    end
    checks++;
    if (locked !== exp_locked) begin
      errors++;
      $display("FAIL %s locked: got %0b expected %0b", name, locked, exp_locked);
    end
    checks++;
    if (busy !== 1'b0 || rx_hold !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: busy=%0b rx_hold=%0b, required 0 0", name, busy, rx_hold);
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] ch, input lens_t lens);
    bit ok;
    int p, d0, e0;
    model(ch, lens, ok, p);
    d0 = done_cycles;
    e0 = err_cycles;
    do_start();
    idle_high(1100);
    send_bits(ch, lens, 10);
    finish_frame(name, ok, p, d0, e0);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (prescale !== 16'd1 || locked !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
        busy !== 1'b0 || rx_hold !== 1'b0) begin
      errors++;
      $display("FAIL %s: prescale=%0d locked=%0b done=%0b error=%0b busy=%0b rx_hold=%0b, required 1 0 0 0 0 0",
               name, prescale, locked, done, error, busy, rx_hold);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cycles + err_cycles !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: pulses %0d busy %0b, required 0 0", done_cycles + err_cycles, busy);
    end
  endtask

  task automatic test_min_width();
    lens_t l;
    fill(l, 7);
    run_frame("width7", 8'h55, l);
    fill(l, 8);
    run_frame("width8", 8'h55, l);
  endtask

  task automatic test_lock_rates();
    lens_t l;
    fill(l, 868);
    run_frame("rate868", 8'h55, l);
    checks++;
    if (prescale !== 16'd109) begin
      errors++;
      $display("FAIL rate868_const: got %0d expected 109", prescale);
    end
    fill(l, 800);
    run_frame("rate800", 8'h55, l);
    checks++;
    if (prescale !== 16'd100 || locked !== 1'b1) begin
      errors++;
      $display("FAIL rate800_const: prescale %0d locked %0b, required 100 1", prescale, locked);
    end
  endtask

  task automatic test_bad_char();
    lens_t l;
    fill(l, 800);
    run_frame("char0f", 8'h0F, l);
    checks++;
    if (prescale !== 16'd100 || locked !== 1'b1) begin
      errors++;
      $display("FAIL char0f_keep: prescale %0d locked %0b, required 100 1", prescale, locked);
    end
  endtask

  task automatic test_timeout();
    int d0, e0;
    d0 = done_cycles;
    e0 = err_cycles;
    do_start();
    idle_high(1100);
    finish_frame("timeout", 1'b0, 0, d0, e0);
  endtask

  task automatic test_idle_low();
    lens_t l;
    bit ok;
    int p, d0, e0;
    d0 = done_cycles;
    e0 = err_cycles;
    rxd = 1'b0;
    do_start();
    repeat (500) @(negedge clk);
    rxd = 1'b1;
    repeat (1000) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done_cycles + err_cycles !== d0 + e0) begin
      errors++;
      $display("FAIL idle_low_wait: busy %0b pulses %0d, required 1 0", busy, done_cycles + err_cycles - d0 - e0);
    end
    repeat (100) @(negedge clk);
    fill(l, 200);
    model(8'h55, l, ok, p);
    send_bits(8'h55, l, 10);
    finish_frame("idle_low", ok, p, d0, e0);
  endtask

  task automatic test_reset_mid();
    lens_t l;
    int d0, e0;
    d0 = done_cycles;
    e0 = err_cycles;
    fill(l, 200);
    do_start();
    idle_high(1100);
    send_bits(8'h55, l, 4);
    rxd = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    exp_prescale = 16'd1;
    exp_locked = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if (done_cycles + err_cycles !== d0 + e0) begin
      errors++;
      $display("FAIL reset_mid_pulses: got %0d pulses, required 0", done_cycles + err_cycles - d0 - e0);
    end
    fill(l, 300);
    run_frame("after_reset", 8'h55, l);
    checks++;
    if (prescale !== 16'd38) begin
      errors++;
      $display("FAIL after_reset_const: got %0d expected 38", prescale);
    end
  endtask

  task automatic test_random();
    lens_t l;
    logic [7:0] ch;
    int base, span;
    for (int it = 0; it < 6; it++) begin
      base = int'($urandom_range(16, 150));
      ch = (it == 5) ? 8'($urandom_range(0, 255)) : 8'h55;
      for (int j = 0; j < 10; j++) begin
        if (it == 4) span = int'($urandom_range(base / 4, 3 * base));
        else         span = base - base / 2 + int'($urandom_range(0, base));
        l[j] = (span < 2) ? 2 : span;
      end
      run_frame($sformatf("random%0d", it), ch, l);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rxd = 1'b1;
    exp_prescale = 16'd1;
    exp_locked = 1'b0;
    test_reset();
    test_min_width();
    test_lock_rates();
    test_bad_char();
    test_timeout();
    test_idle_low();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
